alu_pipe: RTL and testbench

- Parametrised, pipelined successor of the combinational datapath ALU, sitting between operand fetch and writeback in the RISC-V execute stage.
- Accepts one operation per cycle through a valid/ready handshake and carries its result and flags through PIPE_STAGES elastic registers.
- Adds shift-left, set-less-than and signed-overflow/negative flags over the base ALU op set, plus an illegal-opcode indication.

---
 rtl/alu_pipe.sv | 155 +++++++++++++++
 tb/tb_alu_pipe.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Pipelined RISC-V execute ALU: computes result and flags on the accepted input, then carries them through elastic stages.
// Latency: exactly PIPE_STAGES cycles from accept to o_valid when there is no stall. Throughput is one op per cycle.
// Backpressure: stages advance when their successor is empty or advancing. o_ready is combinational from i_ready, and the output holds while stalled.
module alu_pipe #(
    parameter int NB_DATA     = 32,
    parameter int NB_OP_CODE  = 6,
    parameter int PIPE_STAGES = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [NB_OP_CODE-1:0] i_op_code,
    input  logic [NB_DATA-1:0]    i_data_a,
    input  logic [NB_DATA-1:0]    i_data_b,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [NB_DATA-1:0]    o_result,
    output logic                  o_zero,
    output logic                  o_carry,
    output logic                  o_overflow,
    output logic                  o_negative,
    output logic                  o_illegal
);

    localparam int NB_SHAMT = $clog2(NB_DATA);
    localparam int LAST     = PIPE_STAGES - 1;

    localparam logic [NB_OP_CODE-1:0] OP_ADD  = NB_OP_CODE'(6'b100000);
    localparam logic [NB_OP_CODE-1:0] OP_SUB  = NB_OP_CODE'(6'b100010);
    localparam logic [NB_OP_CODE-1:0] OP_AND  = NB_OP_CODE'(6'b100100);
    localparam logic [NB_OP_CODE-1:0] OP_OR   = NB_OP_CODE'(6'b100101);
    localparam logic [NB_OP_CODE-1:0] OP_XOR  = NB_OP_CODE'(6'b100110);
    localparam logic [NB_OP_CODE-1:0] OP_NOR  = NB_OP_CODE'(6'b100111);
    localparam logic [NB_OP_CODE-1:0] OP_SRA  = NB_OP_CODE'(6'b000011);
    localparam logic [NB_OP_CODE-1:0] OP_SRL  = NB_OP_CODE'(6'b000010);
    localparam logic [NB_OP_CODE-1:0] OP_SLL  = NB_OP_CODE'(6'b000000);
    localparam logic [NB_OP_CODE-1:0] OP_SLT  = NB_OP_CODE'(6'b101010);
    localparam logic [NB_OP_CODE-1:0] OP_SLTU = NB_OP_CODE'(6'b101011);

    // Payload carried by every stage. All-zero is also the idle value.
    typedef struct packed {
        logic               illegal;
        logic               negative;
        logic               overflow;
        logic               carry;
        logic               zero;
        logic [NB_DATA-1:0] result;
    } res_t;

    logic [NB_DATA:0]    sum_ext;
    logic [NB_DATA:0]    dif_ext;
    logic [NB_SHAMT-1:0] shamt;
    logic                a_msb;
    logic                b_msb;
    res_t                alu_res;

    logic [PIPE_STAGES-1:0] vld_q;
    logic [PIPE_STAGES-1:0] vld_d;
    logic [PIPE_STAGES-1:0] adv;
    logic                   adv_chain;
    logic                   accept;
    res_t                   dat_q [PIPE_STAGES];
    res_t                   dat_d [PIPE_STAGES];

    // ALU datapath: arithmetic is done one bit wider so carry/borrow falls out of the top bit.
    always_comb begin
        sum_ext = {1'b0, i_data_a} + {1'b0, i_data_b};
        dif_ext = {1'b0, i_data_a} - {1'b0, i_data_b};
        shamt   = i_data_b[NB_SHAMT-1:0];
        a_msb   = i_data_a[NB_DATA-1];
        b_msb   = i_data_b[NB_DATA-1];
        alu_res = '0;
        case (i_op_code)
            OP_ADD: begin
                alu_res.result   = sum_ext[NB_DATA-1:0];
                alu_res.carry    = sum_ext[NB_DATA];
                alu_res.overflow = (a_msb == b_msb) && (sum_ext[NB_DATA-1] != a_msb);
            end
            OP_SUB: begin
                alu_res.result   = dif_ext[NB_DATA-1:0];
                alu_res.carry    = ~dif_ext[NB_DATA];
                alu_res.overflow = (a_msb != b_msb) && (dif_ext[NB_DATA-1] != a_msb);
            end
            OP_AND:  alu_res.result = i_data_a & i_data_b;
            OP_OR:   alu_res.result = i_data_a | i_data_b;
            OP_XOR:  alu_res.result = i_data_a ^ i_data_b;
            OP_NOR:  alu_res.result = ~(i_data_a | i_data_b);
            OP_SRA:  alu_res.result = NB_DATA'($signed(i_data_a) >>> shamt);
            OP_SRL:  alu_res.result = i_data_a >> shamt;
            OP_SLL:  alu_res.result = i_data_a << shamt;
            OP_SLT:  alu_res.result = {{(NB_DATA-1){1'b0}}, ($signed(i_data_a) < $signed(i_data_b))};
            OP_SLTU: alu_res.result = {{(NB_DATA-1){1'b0}}, (i_data_a < i_data_b)};
            default: alu_res.illegal = 1'b1;
        endcase
        // Illegal ops leave the result at 0, so these give zero=1 and negative=0 there as well.
        alu_res.zero     = ~|alu_res.result;
        alu_res.negative = alu_res.result[NB_DATA-1];
    end

    // Advance chain from the output back: a stage moves when anything downstream has a hole or the sink pops.
    always_comb begin
        adv       = '0;
        adv_chain = i_ready;
        for (int k = LAST; k >= 0; k--) begin
            adv[k]    = adv_chain;
            adv_chain = adv_chain | ~vld_q[k];
        end
    end

    assign o_ready = ~vld_q[0] | adv[0];
    assign accept  = i_valid & o_ready;

    // Stage loads. A stage loading a bubble also takes a zero payload, so idle outputs read as 0.
    always_comb begin
        vld_d = vld_q;
        for (int k = 0; k < PIPE_STAGES; k++) begin
            dat_d[k] = dat_q[k];
        end
        if (o_ready) begin
            vld_d[0] = accept;
            dat_d[0] = accept ? alu_res : '0;
        end
        for (int k = 1; k < PIPE_STAGES; k++) begin
            if (~vld_q[k] | adv[k]) begin
                vld_d[k] = vld_q[k-1];
                dat_d[k] = dat_q[k-1];
            end
        end
    end

    // Stage registers. Reset drops every in-flight beat and clears the payload.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            vld_q <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                dat_q[k] <= dat_d[k];
            end
        end
    end

    assign o_valid    = vld_q[LAST];
    assign o_result   = dat_q[LAST].result;
    assign o_zero     = dat_q[LAST].zero;
    assign o_carry    = dat_q[LAST].carry;
    assign o_overflow = dat_q[LAST].overflow;
    assign o_negative = dat_q[LAST].negative;
    assign o_illegal  = dat_q[LAST].illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vectors, backpressure, reset and random traffic against a reference model.
// The reference model uses plain integer arithmetic. A queue acts as the in-order scoreboard.
// Every wait has a bound, and a watchdog ends the run if the simulation stalls.
module tb_alu_pipe;

    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -MAXS - 1;

    logic        i_clock   = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_valid   = 1'b0;
    logic        i_ready   = 1'b0;
    logic [5:0]  i_op_code = '0;
    logic [31:0] i_data_a  = '0;
    logic [31:0] i_data_b  = '0;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_result;
    logic        o_zero;
    logic        o_carry;
    logic        o_overflow;
    logic        o_negative;
    logic        o_illegal;

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q [$];
    logic [5:0]  legal_ops [11] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                                    6'b100111, 6'b000011, 6'b000010, 6'b000000, 6'b101010, 6'b101011};

    alu_pipe #(.NB_DATA(32), .NB_OP_CODE(6), .PIPE_STAGES(2)) dut (
        .i_clock(i_clock), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_op_code(i_op_code), .i_data_a(i_data_a), .i_data_b(i_data_b),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_zero(o_zero),
        .o_carry(o_carry), .o_overflow(o_overflow), .o_negative(o_negative), .o_illegal(o_illegal)
    );

    always #5 i_clock = ~i_clock;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // The packed layout is {illegal, negative, overflow, carry, zero, result}.
    function automatic logic [36:0] model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        longint ua = {32'h0, a};
        longint ub = {32'h0, b};
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        int     sh = int'(b[4:0]);
        logic [31:0] r = '0;
        logic c = 1'b0, v = 1'b0, ill = 1'b0;
        case (op)
            6'b100000: begin r = a + b; c = (ua + ub) > 64'hFFFF_FFFF; v = (sa + sb > MAXS) || (sa + sb < MINS); end
            6'b100010: begin r = a - b; c = (ua >= ub); v = (sa - sb > MAXS) || (sa - sb < MINS); end
            6'b100100: r = a & b;
            6'b100101: r = a | b;
            6'b100110: r = a ^ b;
            6'b100111: r = ~(a | b);
            6'b000011: r = $unsigned($signed(a) >>> sh);
            6'b000010: r = a >> sh;
            6'b000000: r = a << sh;
            6'b101010: r = (sa < sb) ? 32'd1 : 32'd0;
            6'b101011: r = (ua < ub) ? 32'd1 : 32'd0;
            default:   ill = 1'b1;
        endcase
        return {ill, r[31], v, c, (r == 32'd0), r};
    endfunction

    function automatic logic [36:0] dut_out();
        return {o_illegal, o_negative, o_overflow, o_carry, o_zero, o_result};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_rand();
        int idx = $urandom_range(0, 11);
        i_op_code = (idx == 11) ? 6'($urandom) : legal_ops[idx];
        i_data_a  = $urandom;
        i_data_b  = $urandom;
    endtask

    // One clock: check the output against the scoreboard, then update the model on the handshakes.
    task automatic tick(output bit in_fire);
        bit out_fire;
        #1;
        in_fire  = i_valid && o_ready;
        out_fire = o_valid && i_ready;
        if (o_valid) begin
            chk("sb_expected_beat", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("sb_payload", 64'(dut_out()), 64'(exp_q[0]));
        end else begin
            chk("sb_idle_zero", 64'(dut_out()), 64'd0);
        end
        @(posedge i_clock);
        if (out_fire && exp_q.size() != 0) void'(exp_q.pop_front());
        if (in_fire) exp_q.push_back(model(i_op_code, i_data_a, i_data_b));
        @(negedge i_clock);
    endtask

    task automatic drain();
        bit f;
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) tick(f);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // A single beat with i_ready high. Checks the two-cycle latency and the result against a constant.
    task automatic dir(input string tag, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [36:0] exp);
        bit f;
        i_ready = 1'b1; i_valid = 1'b1; i_op_code = op; i_data_a = a; i_data_b = b;
        tick(f);
        chk({tag, "_accept"}, 64'(f), 64'd1);
        i_valid = 1'b0;
        #1 chk({tag, "_lat_early"}, 64'(o_valid), 64'd0);
        tick(f);
        #1 chk({tag, "_vld"}, 64'(o_valid), 64'd1);
        chk(tag, 64'(dut_out()), 64'(exp));
        tick(f);
    endtask

    initial begin
        bit f;
        int n;
        logic [36:0] hold;

        // Reset state
        #2 chk("rst_out", 64'(dut_out()), 64'd0);
        chk("rst_vld", 64'(o_valid), 64'd0);
        repeat (2) @(negedge i_clock);
        i_reset_n = 1'b1;
        #1 chk("rst_rdy", 64'(o_ready), 64'd1);
        @(negedge i_clock);

        // Directed vectors
        dir("add_wrap", 6'b100000, 32'hFFFF_FFFF, 32'h1, {5'b00011, 32'h0000_0000});
        dir("add_ovf",  6'b100000, 32'h7FFF_FFFF, 32'h1, {5'b01100, 32'h8000_0000});
        dir("sub_neg",  6'b100010, 32'd5, 32'd7,         {5'b01000, 32'hFFFF_FFFE});
        dir("sub_pos",  6'b100010, 32'd7, 32'd5,         {5'b00010, 32'h0000_0002});
        dir("sub_ovf",  6'b100010, 32'h8000_0000, 32'h1, {5'b00110, 32'h7FFF_FFFF});
        dir("slt",      6'b101010, 32'h8000_0000, 32'h1, {5'b00000, 32'h0000_0001});
        dir("sltu",     6'b101011, 32'h8000_0000, 32'h1, {5'b00001, 32'h0000_0000});
        dir("sra",      6'b000011, 32'h8000_0000, 32'h24, {5'b01000, 32'hF800_0000});
        dir("srl",      6'b000010, 32'h8000_0000, 32'h24, {5'b00000, 32'h0800_0000});
        dir("sll",      6'b000000, 32'h1, 32'd31,        {5'b01000, 32'h8000_0000});
        dir("xor_zero", 6'b100110, 32'hA5A5_A5A5, 32'hA5A5_A5A5, {5'b00001, 32'h0});
        dir("nor",      6'b100111, 32'h0, 32'h0,         {5'b01000, 32'hFFFF_FFFF});
        dir("and",      6'b100100, 32'hF0F0_F0F0, 32'hFF00_FF00, {5'b01000, 32'hF000_F000});
        dir("illegal",  6'b111111, 32'h1234_5678, 32'h9, {5'b10001, 32'h0});

        // Back-to-back at full rate: o_ready must stay high while accepts and pops overlap
        i_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            i_valid = 1'b1;
            drive_rand();
            #1 chk("tput_rdy", 64'(o_ready), 64'd1);
            tick(f);
        end
        drain();

        // Backpressure: two accepts fill the pipe, then the output holds
        i_ready = 1'b0;
        i_valid = 1'b1;
        drive_rand();
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            tick(f);
            if (f) begin n++; drive_rand(); end
        end
        chk("bp_two_accepts", 64'(n), 64'd2);
        #1 chk("bp_rdy_low", 64'(o_ready), 64'd0);
        hold = dut_out();
        for (int i = 0; i < 5; i++) begin
            tick(f);
            chk("bp_no_accept", 64'(f), 64'd0);
            #1 chk("bp_hold", 64'(dut_out()), 64'(hold));
        end
        i_ready = 1'b1;
        for (int c = 0; c < 40 && n < 6; c++) begin
            tick(f);
            if (f) begin n++; drive_rand(); end
        end
        chk("bp_six_accepts", 64'(n), 64'd6);
        drain();

        // Random i_valid and i_ready toggling
        n = 0;
        for (int c = 0; c < 20000 && n < 1000; c++) begin
            i_valid = 1'($urandom_range(0, 1));
            i_ready = 1'($urandom_range(0, 1));
            drive_rand();
            tick(f);
            if (f) n++;
        end
        chk("rnd_count", 64'(n), 64'd1000);
        drain();

        // Asynchronous reset with beats in flight
        i_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            i_valid = 1'b1; i_op_code = 6'b100000;
            i_data_a = 32'h100 * i; i_data_b = i;
            tick(f);
        end
        #1 chk("mid_vld_before_rst", 64'(o_valid), 64'd1);
        #1 i_reset_n = 1'b0;
        #1 chk("mid_rst_vld", 64'(o_valid), 64'd0);
        chk("mid_rst_out", 64'(dut_out()), 64'd0);
        exp_q.delete();
        i_valid = 1'b0;
        @(negedge i_clock);
        i_reset_n = 1'b1;
        #1 chk("mid_rst_rdy", 64'(o_ready), 64'd1);
        @(negedge i_clock);
        for (int i = 0; i < 6; i++) tick(f);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
